// File: rtl/wb_rr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_rr_arbiter_if : initiator-side and target-side Wishbone bundle          |
// |                    for wb_rr_arbiter                                       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface wb_rr_arbiter_if #(
    parameter int ITR_CNT    = 4,
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGRD_WIDTH = 1,
    parameter int TGWD_WIDTH = 1
) ();
    logic [ITR_CNT-1:0]            itr_cyc_i;
    logic [ITR_CNT-1:0]            itr_stb_i;
    logic [ITR_CNT-1:0]            itr_we_i;
    logic [ITR_CNT-1:0]            itr_lock_i;
    logic [ITR_CNT*SEL_WIDTH-1:0]  itr_sel_i;
    logic [ITR_CNT*ADR_WIDTH-1:0]  itr_adr_i;
    logic [ITR_CNT*DAT_WIDTH-1:0]  itr_dat_i;
    logic [ITR_CNT*TGA_WIDTH-1:0]  itr_tga_i;
    logic [ITR_CNT*TGC_WIDTH-1:0]  itr_tgc_i;
    logic [ITR_CNT*TGWD_WIDTH-1:0] itr_tgd_i;
    logic [ITR_CNT-1:0]            itr_ack_o;
    logic [ITR_CNT-1:0]            itr_err_o;
    logic [ITR_CNT-1:0]            itr_rty_o;
    logic [ITR_CNT-1:0]            itr_stall_o;
    logic [DAT_WIDTH-1:0]          itr_dat_o;
    logic [TGRD_WIDTH-1:0]         itr_tgd_o;

    logic                          tgt_cyc_o;
    logic                          tgt_stb_o;
    logic                          tgt_we_o;
    logic                          tgt_lock_o;
    logic [SEL_WIDTH-1:0]          tgt_sel_o;
    logic [ADR_WIDTH-1:0]          tgt_adr_o;
    logic [DAT_WIDTH-1:0]          tgt_dat_o;
    logic [TGA_WIDTH-1:0]          tgt_tga_o;
    logic [TGC_WIDTH-1:0]          tgt_tgc_o;
    logic [TGWD_WIDTH-1:0]         tgt_tgd_o;
    logic                          tgt_ack_i;
    logic                          tgt_err_i;
    logic                          tgt_rty_i;
    logic                          tgt_stall_i;
    logic [DAT_WIDTH-1:0]          tgt_dat_i;
    logic [TGRD_WIDTH-1:0]         tgt_tgd_i;

    logic [ITR_CNT-1:0]            gnt_o;

    modport slave (
        input  itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i,
        input  itr_sel_i, itr_adr_i, itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i,
        output itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o, itr_dat_o, itr_tgd_o,
        output tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o,
        output tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o,
        input  tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i, tgt_dat_i, tgt_tgd_i,
        output gnt_o
    );

    modport master (
        output itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i,
        output itr_sel_i, itr_adr_i, itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i,
        input  itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o, itr_dat_o, itr_tgd_o,
        input  tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o,
        input  tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o,
        output tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i, tgt_dat_i, tgt_tgd_i,
        input  gnt_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_rr_arbiter : shares one pipelined Wishbone target among ITR_CNT         |
// |   initiators. Round-robin when WBXBC_ARB_RR_EN is defined, else fixed      |
// |   priority (index 0 highest). Revision 1.0                                 |
// +----------------------------------------------------------------------------+
module wb_rr_arbiter #(
    parameter int ITR_CNT    = 4,
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGRD_WIDTH = 1,
    parameter int TGWD_WIDTH = 1
) (
    input  wire logic       clk_i,
    input  wire logic       sync_rst_i,
    wb_rr_arbiter_if.slave  bus
);
    logic [ITR_CNT-1:0] gnt_q;
    logic [ITR_CNT-1:0] gnt_d;
    logic               hold;

    // Lock keeps the current owner even while its cycle line is low.
    assign hold = |(gnt_q & (bus.itr_cyc_i | bus.itr_lock_i));

`ifdef WBXBC_ARB_RR_EN
    localparam int PTR_WIDTH = $clog2(ITR_CNT);
    logic [PTR_WIDTH-1:0] ptr_q;
    logic [PTR_WIDTH-1:0] ptr_d;

    // Descending scan overwrites, so the requester closest after ptr_q wins.
    always_comb begin
        logic [PTR_WIDTH-1:0] idx;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        idx   = '0;
        if (!hold) begin
            gnt_d = '0;
            for (int k = ITR_CNT; k >= 1; k--) begin
                idx = PTR_WIDTH'((int'(ptr_q) + k) % ITR_CNT);
                if (bus.itr_cyc_i[idx]) begin
                    gnt_d      = '0;
                    gnt_d[idx] = 1'b1;
                    ptr_d      = idx;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            gnt_q <= '0;
            ptr_q <= PTR_WIDTH'(ITR_CNT - 1);
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt_d = gnt_q;
        if (!hold) begin
            gnt_d = '0;
            for (int i = ITR_CNT - 1; i >= 0; i--) begin
                if (bus.itr_cyc_i[i]) begin
                    gnt_d    = '0;
                    gnt_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            gnt_q <= '0;
        end else begin
            gnt_q <= gnt_d;
        end
    end
`endif

    logic                  cyc_m, stb_m, we_m, lock_m;
    logic [SEL_WIDTH-1:0]  sel_m;
    logic [ADR_WIDTH-1:0]  adr_m;
    logic [DAT_WIDTH-1:0]  dat_m;
    logic [TGA_WIDTH-1:0]  tga_m;
    logic [TGC_WIDTH-1:0]  tgc_m;
    logic [TGWD_WIDTH-1:0] tgd_m;

    always_comb begin
        cyc_m  = 1'b0;
        stb_m  = 1'b0;
        we_m   = 1'b0;
        lock_m = 1'b0;
        sel_m  = '0;
        adr_m  = '0;
        dat_m  = '0;
        tga_m  = '0;
        tgc_m  = '0;
        tgd_m  = '0;
        for (int i = 0; i < ITR_CNT; i++) begin
            if (gnt_q[i]) begin
                cyc_m  = cyc_m  | bus.itr_cyc_i[i];
                stb_m  = stb_m  | bus.itr_stb_i[i];
                we_m   = we_m   | bus.itr_we_i[i];
                lock_m = lock_m | bus.itr_lock_i[i];
                sel_m  = sel_m  | bus.itr_sel_i[i*SEL_WIDTH  +: SEL_WIDTH];
                adr_m  = adr_m  | bus.itr_adr_i[i*ADR_WIDTH  +: ADR_WIDTH];
                dat_m  = dat_m  | bus.itr_dat_i[i*DAT_WIDTH  +: DAT_WIDTH];
                tga_m  = tga_m  | bus.itr_tga_i[i*TGA_WIDTH  +: TGA_WIDTH];
                tgc_m  = tgc_m  | bus.itr_tgc_i[i*TGC_WIDTH  +: TGC_WIDTH];
                tgd_m  = tgd_m  | bus.itr_tgd_i[i*TGWD_WIDTH +: TGWD_WIDTH];
            end
        end
    end

    assign bus.tgt_cyc_o   = cyc_m;
    assign bus.tgt_stb_o   = stb_m;
    assign bus.tgt_we_o    = we_m;
    assign bus.tgt_lock_o  = lock_m;
    assign bus.tgt_sel_o   = sel_m;
    assign bus.tgt_adr_o   = adr_m;
    assign bus.tgt_dat_o   = dat_m;
    assign bus.tgt_tga_o   = tga_m;
    assign bus.tgt_tgc_o   = tgc_m;
    assign bus.tgt_tgd_o   = tgd_m;

    assign bus.itr_ack_o   = gnt_q & {ITR_CNT{bus.tgt_ack_i}};
    assign bus.itr_err_o   = gnt_q & {ITR_CNT{bus.tgt_err_i}};
    assign bus.itr_rty_o   = gnt_q & {ITR_CNT{bus.tgt_rty_i}};
    assign bus.itr_stall_o = ~gnt_q | {ITR_CNT{bus.tgt_stall_i}};
    assign bus.itr_dat_o   = bus.tgt_dat_i;
    assign bus.itr_tgd_o   = bus.tgt_tgd_i;
    assign bus.gnt_o       = gnt_q;
endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wb_rr_arbiter : directed bench for wb_rr_arbiter (4 initiators)         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_wb_rr_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    wb_rr_arbiter_if #(.ITR_CNT(4)) bus ();

    wb_rr_arbiter #(.ITR_CNT(4)) dut (
        .clk_i      (clk),
        .sync_rst_i (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [3:0] exp_seq [5];

    initial begin
`ifdef WBXBC_ARB_RR_EN
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
`else
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0001;
        exp_seq[3] = 4'b0010; exp_seq[4] = 4'b0001;
`endif
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        bus.itr_cyc_i  = '0;
        bus.itr_stb_i  = '0;
        bus.itr_we_i   = '0;
        bus.itr_lock_i = '0;
        bus.itr_sel_i  = {2'b11, 2'b10, 2'b01, 2'b00};
        bus.itr_adr_i  = {16'h4444, 16'h1234, 16'h2222, 16'h1111};
        bus.itr_dat_i  = {16'hD3D3, 16'hA5A5, 16'hD1D1, 16'hD0D0};
        bus.itr_tga_i  = 4'b0100;
        bus.itr_tgc_i  = 4'b0100;
        bus.itr_tgd_i  = 4'b0100;
        bus.tgt_ack_i   = 1'b0;
        bus.tgt_err_i   = 1'b0;
        bus.tgt_rty_i   = 1'b0;
        bus.tgt_stall_i = 1'b0;
        bus.tgt_dat_i   = '0;
        bus.tgt_tgd_i   = '0;

        // Reset
        tick();
        tick();
        chk("rst_gnt",   32'(bus.gnt_o),       32'h0);
        chk("rst_cyc",   32'(bus.tgt_cyc_o),   32'h0);
        chk("rst_stall", 32'(bus.itr_stall_o), 32'hF);
        chk("rst_ack",   32'(bus.itr_ack_o),   32'h0);
        chk("rst_adr",   32'(bus.tgt_adr_o),   32'h0);
        rst = 1'b0;
        tick();

        // Single request from initiator 2
        bus.itr_cyc_i = 4'b0100;
        bus.itr_stb_i = 4'b0100;
        bus.itr_we_i  = 4'b0100;
        #1;
        chk("single_lat_cyc", 32'(bus.tgt_cyc_o), 32'h0);
        tick();
        chk("single_gnt", 32'(bus.gnt_o),     32'h4);
        chk("single_adr", 32'(bus.tgt_adr_o), 32'h1234);
        chk("single_dat", 32'(bus.tgt_dat_o), 32'hA5A5);
        chk("single_sel", 32'(bus.tgt_sel_o), 32'h2);
        chk("single_cyc", 32'(bus.tgt_cyc_o), 32'h1);
        chk("single_we",  32'(bus.tgt_we_o),  32'h1);
        chk("single_tga", 32'(bus.tgt_tga_o), 32'h1);
        chk("single_stall", 32'(bus.itr_stall_o), 32'hB);
        bus.tgt_ack_i = 1'b1;
        bus.tgt_dat_i = 16'hBEEF;
        #1;
        chk("single_ack",  32'(bus.itr_ack_o), 32'h4);
        chk("single_rdat", 32'(bus.itr_dat_o), 32'hBEEF);
        bus.tgt_ack_i = 1'b0;
        bus.tgt_err_i = 1'b1;
        #1;
        chk("single_err", 32'(bus.itr_err_o), 32'h4);
        bus.tgt_err_i = 1'b0;
        bus.itr_cyc_i = '0;
        bus.itr_stb_i = '0;
        bus.itr_we_i  = '0;
        tick();
        chk("single_idle", 32'(bus.gnt_o), 32'h0);

        // Handoff 0 -> 1
        bus.itr_cyc_i = 4'b0001;
        tick();
        chk("ho_gnt0", 32'(bus.gnt_o), 32'h1);
        bus.itr_cyc_i = 4'b0010;
        #1;
        chk("ho_gap_cyc", 32'(bus.tgt_cyc_o), 32'h0);
        tick();
        chk("ho_gnt1", 32'(bus.gnt_o),     32'h2);
        chk("ho_cyc",  32'(bus.tgt_cyc_o), 32'h1);
        chk("ho_adr",  32'(bus.tgt_adr_o), 32'h2222);
        bus.itr_cyc_i = '0;
        tick();

        // Reset mid-cycle
        bus.itr_cyc_i = 4'b0001;
        tick();
        chk("mrst_gnt0", 32'(bus.gnt_o), 32'h1);
        bus.tgt_stall_i = 1'b1;
        rst = 1'b1;
        tick();
        chk("mrst_gnt",   32'(bus.gnt_o),       32'h0);
        chk("mrst_cyc",   32'(bus.tgt_cyc_o),   32'h0);
        chk("mrst_stall", 32'(bus.itr_stall_o), 32'hF);
        rst = 1'b0;
        bus.itr_cyc_i   = '0;
        bus.tgt_stall_i = 1'b0;
        tick();

        // Arbitration order with all four requesting
        bus.itr_cyc_i = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("arb_gnt%0d", k), 32'(bus.gnt_o), 32'(exp_seq[k]));
            bus.tgt_ack_i = 1'b1;
            #1;
            chk($sformatf("arb_ack%0d", k), 32'(bus.itr_ack_o), 32'(exp_seq[k]));
            bus.itr_cyc_i = (k == 4) ? 4'b0000 : (4'b1111 & ~exp_seq[k]);
            tick();
            bus.tgt_ack_i = 1'b0;
            if (k != 4) bus.itr_cyc_i = 4'b1111;
        end
        chk("arb_idle", 32'(bus.gnt_o), 32'h0);

        // Lock holds grant across a cycle gap
        bus.itr_cyc_i  = 4'b0010;
        bus.itr_lock_i = 4'b0010;
        tick();
        chk("lock_gnt", 32'(bus.gnt_o), 32'h2);
        bus.itr_cyc_i = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("lock_hold%0d", k), 32'(bus.gnt_o), 32'h2);
        end
        chk("lock_tgt_lock", 32'(bus.tgt_lock_o), 32'h1);
        chk("lock_tgt_cyc",  32'(bus.tgt_cyc_o),  32'h0);
        bus.itr_lock_i = '0;
        tick();
        chk("lock_release", 32'(bus.gnt_o),     32'h8);
        chk("lock_adr",     32'(bus.tgt_adr_o), 32'h4444);
        bus.itr_cyc_i = '0;
        tick();
        chk("end_idle", 32'(bus.gnt_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
